four_bit_divider: RTL and testbench

Sequential unsigned restoring divider. Computes quotient Q = A / B and remainder R = A % B for WIDTH-bit operands, one quotient bit per clock. Serves as the divide unit of the ALSU datapath, launched by a start pulse and completing with a one-cycle done pulse.

---
 rtl/four_bit_divider_pkg.sv | 33 +++
 rtl/four_bit_divider_div_step.sv | 45 ++++
 rtl/four_bit_divider.sv | 183 ++++++++++++++++++
 tb/tb_four_bit_divider.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_divider_pkg.sv
// -----------------------------------------------------------------------------
// four_bit_divider_pkg
// Shared definitions for the sequential restoring divider:
//   - DEFAULT_WIDTH : default operand / quotient / remainder width
//   - state_t       : divider control FSM states (IDLE / RUN / DONE)
//   - cnt_width()   : width of the step counter for a given operand width
//   - CNT_W         : step counter width for the default operand width
// -----------------------------------------------------------------------------
package four_bit_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        if (cw < 1) begin
            cw = 1;
        end else begin
            cw = cw;
        end
        return cw;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/four_bit_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift the partial
// remainder left, bring in the next dividend bit, and subtract the divisor
// when it fits.
// Ports:
//   rem_in       : partial remainder entering the step (always < divisor,
//                  or the raw shifted-in dividend bits when divisor is 0)
//   dividend_msb : next dividend bit, MSB first
//   divisor      : divisor
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted value carries one extra bit so the compare with the
    // divisor cannot overflow (e.g. remainder 14 shifted with a 1 -> 29).
    logic [WIDTH:0] shifted_s;

    // Restoring step: subtract only when the divisor fits.
    always_comb begin
        shifted_s = {rem_in, dividend_msb};
        rem_out   = shifted_s[WIDTH-1:0];
        q_bit     = 1'b0;
        if (shifted_s >= {1'b0, divisor}) begin
            // Result is below the divisor, so it always fits in WIDTH bits.
            rem_out = WIDTH'(shifted_s - {1'b0, divisor});
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s[WIDTH-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/four_bit_divider.sv
// -----------------------------------------------------------------------------
// four_bit_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
// Q = A / B, R = A % B after WIDTH cycles. B = 0 yields Q = all ones, R = A.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   start       : launch request, accepted in IDLE and in the DONE cycle
//   A, B        : dividend / divisor (unsigned), latched at launch
//   busy        : division in progress
//   done        : one-cycle pulse when Q/R update
//   Q, R        : registered quotient / remainder, hold until next result
//   div_by_zero : (only with DIVIDER_DIV_ZERO_FLAG_EN defined) registered
//                 with Q/R, set when the completed division had B = 0
// -----------------------------------------------------------------------------
module four_bit_divider
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;     // dividend, quotient bits shift into LSB
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] rem_nxt_s;
    logic             q_bit_s;
    logic             launch_s;
    logic             last_s;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (rem_r),
        .dividend_msb(dvd_r[WIDTH-1]),
        .divisor     (dvs_r),
        .rem_out     (rem_nxt_s),
        .q_bit       (q_bit_s)
    );

    // Launch allowed whenever no division is running (IDLE or DONE).
    always_comb begin
        launch_s = 1'b0;
        last_s   = 1'b0;
        if (state_r != RUN) begin
            launch_s = start;
        end else begin
            launch_s = 1'b0;
        end
        if ((state_r == RUN) && (cnt_r == CW'(0))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (launch_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Working registers: latch operands on launch, iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= '0;
            dvd_r <= '0;
            dvs_r <= '0;
            cnt_r <= '0;
        end else if (launch_s) begin
            rem_r <= '0;
            dvd_r <= A;
            dvs_r <= B;
            cnt_r <= CW'(WIDTH - 1);
        end else if (state_r == RUN) begin
            rem_r <= rem_nxt_s;
            dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
            cnt_r <= cnt_r - CW'(1);
        end else begin
            rem_r <= rem_r;
            dvd_r <= dvd_r;
            dvs_r <= dvs_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers load only on the final step, so no partial values leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
            r_r <= '0;
        end else if (last_s) begin
            q_r <= {dvd_r[WIDTH-2:0], q_bit_s};
            r_r <= rem_nxt_s;
        end else begin
            q_r <= q_r;
            r_r <= r_r;
        end
    end

`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    logic dbz_r;

    // Divide-by-zero flag travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_r <= 1'b0;
        end else if (last_s) begin
            dbz_r <= (dvs_r == '0);
        end else begin
            dbz_r <= dbz_r;
        end
    end

    assign div_by_zero = dbz_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign Q    = q_r;
    assign R    = r_r;

endmodule

// File: tb/tb_four_bit_divider.sv
// -----------------------------------------------------------------------------
// tb_four_bit_divider
// Scoreboard bench: expected {Q, R} are pushed when a launch is driven and
// popped when done is observed. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_four_bit_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    int n_vec;
    int n_err;

    logic [2*W-1:0] exp_q[$];      // {Q, R}
    logic           exp_z[$];      // expected div_by_zero

    four_bit_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R)
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
        ,
        .div_by_zero(div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for one division.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == 4'd0) begin
            q = 4'hF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Drive a one-cycle start pulse and push the expected result.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
        exp_z.push_back(b == 4'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports cycles waited.
    task automatic wait_done(output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                cycles = cycles + 1;
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int  cyc;
        bit  seen;
        logic [2*W-1:0] e;
        bit  pulsed;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, Q, R} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b Q=%0d R=%0d, want all 0", busy, done, Q, R);
        end
        rst_n = 1'b1;
        // Leave a nonzero result so the later reset clearing is visible.
        launch(4'd5, 4'd3);
        wait_done(cyc, seen);
        e = exp_q.pop_front();
        void'(exp_z.pop_front());
        n_vec++;
        if (!seen || {Q, R} !== e) begin
            n_err++;
            $display("FAIL reset_pre: seen=%0d Q=%0d R=%0d, want Q=%0d R=%0d", seen, Q, R, e[7:4], e[3:0]);
        end
        // Abort a running 15/3.
        launch(4'd15, 4'd3);
        void'(exp_q.pop_front());
        void'(exp_z.pop_front());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, Q, R} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b done=%b Q=%0d R=%0d, want all 0", busy, done, Q, R);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
        end
        n_vec++;
        if (pulsed) begin
            n_err++;
            $display("FAIL reset_no_done: activity after aborted division, want none");
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[9] = '{4'd5, 4'd5, 4'd0, 4'd15, 4'd3, 4'd10, 4'd12, 4'd15, 4'd10};
        logic [W-1:0] tb[9] = '{4'd4, 4'd3, 4'd1, 4'd3,  4'd5, 4'd1,  4'd13, 4'd15, 4'd5};
        int  cyc;
        bit  seen;
        logic [2*W-1:0] e;
        for (int i = 0; i < 9; i++) begin
            launch(ta[i], tb[i]);
            wait_done(cyc, seen);
            e = exp_q.pop_front();
            void'(exp_z.pop_front());
            n_vec++;
            if (!seen || {Q, R} !== e) begin
                n_err++;
                $display("FAIL basic %0d/%0d: seen=%0d Q=%0d R=%0d, want Q=%0d R=%0d",
                         ta[i], tb[i], seen, Q, R, e[7:4], e[3:0]);
            end
        end
    endtask

    task automatic test_latency();
        int  cyc;
        bit  seen;
        logic [2*W-1:0] e;
        launch(4'd12, 4'd5);
        // Busy check right after the start edge, then a start that must be ignored.
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: busy=%b, want 1", busy);
        end
        A     = 4'd7;
        B     = 4'd2;
        start = 1'b1;
        wait_done(cyc, seen);
        start = 1'b0;
        n_vec++;
        if (!seen || cyc != 4) begin
            n_err++;
            $display("FAIL latency: seen=%0d cycles=%0d, want 4", seen, cyc);
        end
        e = exp_q.pop_front();
        void'(exp_z.pop_front());
        n_vec++;
        if ({Q, R} !== e || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_busy_start: Q=%0d R=%0d busy=%b, want Q=%0d R=%0d busy=0",
                     Q, R, busy, e[7:4], e[3:0]);
        end
        // The done-cycle start above was never held into this cycle, so idle.
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  seen;
        bit  moved;
        logic [2*W-1:0] e;
        launch(4'd15, 4'd3);
        wait_done(cyc, seen);
        e = exp_q.pop_front();
        void'(exp_z.pop_front());
        n_vec++;
        if (!seen || {Q, R} !== e) begin
            n_err++;
            $display("FAIL b2b_first: Q=%0d R=%0d, want Q=%0d R=%0d", Q, R, e[7:4], e[3:0]);
        end
        // Launch in the done cycle.
        A     = 4'd9;
        B     = 4'd4;
        start = 1'b1;
        exp_q.push_back(model(4'd9, 4'd4));
        exp_z.push_back(1'b0);
        @(negedge clk);
        start = 1'b0;
        A     = 4'd1;   // later operand changes must not matter
        B     = 4'd1;
        moved = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                if (done === 1'b1) seen = 1'b1;
                else if ({Q, R} !== 8'h50) moved = 1'b1;
                if (!seen) @(negedge clk);
            end
        end
        n_vec++;
        if (moved) begin
            n_err++;
            $display("FAIL b2b_hold: Q/R changed before done, want Q=5 R=0 held");
        end
        e = exp_q.pop_front();
        void'(exp_z.pop_front());
        n_vec++;
        if (!seen || {Q, R} !== e) begin
            n_err++;
            $display("FAIL b2b_second: seen=%0d Q=%0d R=%0d, want Q=%0d R=%0d",
                     seen, Q, R, e[7:4], e[3:0]);
        end
    endtask

    task automatic test_div_zero();
        int  cyc;
        bit  seen;
        logic [2*W-1:0] e;
        logic ez;
        logic [W-1:0] bs[2] = '{4'd0, 4'd2};
        for (int i = 0; i < 2; i++) begin
            launch(4'd6, bs[i]);
            wait_done(cyc, seen);
            e  = exp_q.pop_front();
            ez = exp_z.pop_front();
            n_vec++;
            if (!seen || cyc != 4 || {Q, R} !== e) begin
                n_err++;
                $display("FAIL div_zero 6/%0d: cyc=%0d Q=%0d R=%0d, want cyc=4 Q=%0d R=%0d",
                         bs[i], cyc, Q, R, e[7:4], e[3:0]);
            end
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
            n_vec++;
            if (div_by_zero !== ez) begin
                n_err++;
                $display("FAIL dbz_flag 6/%0d: got %b, want %b", bs[i], div_by_zero, ez);
            end
`else
            ez = ez;
`endif
        end
    endtask

    task automatic test_exhaustive();
        int  cyc;
        bit  seen;
        logic [2*W-1:0] e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(W'(a), W'(b));
                wait_done(cyc, seen);
                e = exp_q.pop_front();
                void'(exp_z.pop_front());
                n_vec++;
                if (!seen || {Q, R} !== e) begin
                    n_err++;
                    $display("FAIL exhaustive %0d/%0d: Q=%0d R=%0d, want Q=%0d R=%0d",
                             a, b, Q, R, e[7:4], e[3:0]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_latency();
        test_back_to_back();
        test_div_zero();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
